mem_stage_mc: RTL
=================

MEM_STAGE_MC -- requirements
Module: mem_stage_mc

Interface
REQ-001 Parameter XLEN, default 32, meaning: datapath and address width; only 32 and 64 are legal.
REQ-002 Parameter RESET_PC, default 32'h1c000000 zero-extended to XLEN, meaning: reset value of pc_out.
REQ-003 Ports: clk input 1, the single clock; rst input 1, reset; synchronous and active-high.
REQ-004 Ports: in_valid input 1, upstream valid; in_ready output 1, stage can accept.
REQ-005 Ports: out_valid output 1, result valid; out_ready input 1, downstream accepts.
REQ-006 Ports: pc input XLEN; alu_result input XLEN, effective address or ALU result; rkd_value input XLEN, store data.
REQ-007 Ports: res_from_mem input 1, load; mem_we input 1, store; gr_we input 1; dest input 5.
REQ-008 Ports: mem_size input 2, 0 = byte, 1 = half, 2 = word, 3 = double (XLEN=64 only); mem_unsigned input 1, zero-extend load.
REQ-009 Ports: data_req output 1; data_wr output 1; data_wstrb output XLEN/8; data_addr output XLEN; data_wdata output XLEN.
REQ-010 Ports: data_addr_ok input 1, request accepted; data_data_ok input 1, response valid; data_rdata input XLEN.
REQ-011 Ports: pc_out output XLEN; result_out output XLEN; gr_we_out output 1; dest_out output 5; ale_out output 1, misaligned-access flag.

Function
REQ-012 in_ready SHALL be ~rst & (state==IDLE | (state==DONE & out_ready)).
REQ-013 On accept (in_valid & in_ready), the stage SHALL latch all input fields; the FSM SHALL go to REQ for an aligned load or store, otherwise to DONE.
REQ-014 Alignment SHALL be checked on the low address bits against 2^mem_size bytes; mem_size=3 with XLEN=32 SHALL count as misaligned.
REQ-015 A misaligned load or store SHALL issue no bus request, SHALL go to DONE with ale_out=1 and gr_we_out=0, and SHALL leave result_out equal to alu_result.
REQ-016 In REQ, data_req SHALL be 1 and data_addr, data_wr, data_wstrb and data_wdata SHALL be held stable until data_addr_ok.
REQ-017 data_req & data_addr_ok SHALL move the FSM to WAIT; data_req SHALL be 0 in every state other than REQ.
REQ-018 In WAIT, data_data_ok SHALL move the FSM to DONE and, for a load, capture the processed read data; a store SHALL also wait for data_data_ok.
REQ-019 data_addr SHALL be the latched alu_result with the low log2(XLEN/8) bits cleared; data_wr SHALL be the latched mem_we.
REQ-020 For stores, data_wdata SHALL be the low 2^mem_size bytes of rkd_value replicated across all lanes; data_wstrb SHALL set 2^mem_size bits starting at the address byte offset.
REQ-021 For loads, the stage SHALL shift data_rdata right by 8 times the byte offset, keep 2^mem_size bytes, and sign-extend to XLEN unless mem_unsigned=1.
REQ-022 out_valid SHALL be 1 exactly in DONE; result_out SHALL be the extended load data for a load, otherwise the latched alu_result.
REQ-023 DONE & out_ready SHALL go to IDLE, or SHALL take the next transaction in the same cycle if in_valid=1; DONE & ~out_ready SHALL hold all outputs.
REQ-024 Latency: a non-memory op accepted in cycle N SHALL be out_valid in N+1; a load with addr_ok in cycle A and data_ok in cycle D (D>A) SHALL be out_valid in D+1.
REQ-025 data_data_ok in REQ or IDLE SHALL be ignored; data_addr_ok outside REQ SHALL be ignored.

Reset
REQ-026 While rst=1 the FSM SHALL go to IDLE; out_valid, data_req, gr_we_out and ale_out SHALL be 0; pc_out SHALL be RESET_PC; result_out and dest_out SHALL be 0.
REQ-027 Reset in REQ or WAIT SHALL abandon the transaction with no further data_req, and any later data_data_ok SHALL be ignored.
REQ-028 in_ready SHALL be 0 during the reset cycle.

Verification
REQ-029 ALU op pc=0x1c000010, alu_result=0x55, gr_we=1, dest=3, out_ready=1 -> out_valid the next cycle with result_out=0x55, dest_out=3.
REQ-030 Load byte signed, addr 0x1003, rdata 0x80aabbcc, addr_ok delayed 2 cycles, data_ok 3 cycles later -> data_addr=0x1000, data_req held for 3 cycles, result_out=0xffffff80.
REQ-031 Store half, addr 0x2002, rkd_value 0x1234abcd -> data_wstrb=4'b1100, data_wdata=0xabcdabcd, data_wr=1, out_valid after data_data_ok.
REQ-032 Load word at 0x3001 -> data_req never asserted, ale_out=1, gr_we_out=0, out_valid the next cycle.
REQ-033 out_ready=0 for 4 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 with in_valid=1 -> new op accepted the same cycle.
REQ-034 rst asserted during WAIT, then a stray data_data_ok -> out_valid stays 0, FSM IDLE, pc_out=0x1c000000.

Source files
------------

// File: rtl/mem_stage_mc.sv
// Multi-cycle memory stage: one transaction at a time, bus request/response
// handshake, load alignment and extension, store lane replication.
module mem_stage_mc #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h1c000000)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     alu_result,
  input  logic [XLEN-1:0]     rkd_value,
  input  logic                res_from_mem,
  input  logic                mem_we,
  input  logic                gr_we,
  input  logic [4:0]          dest,
  input  logic [1:0]          mem_size,
  input  logic                mem_unsigned,
  output logic                data_req,
  output logic                data_wr,
  output logic [XLEN/8-1:0]   data_wstrb,
  output logic [XLEN-1:0]     data_addr,
  output logic [XLEN-1:0]     data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [XLEN-1:0]     data_rdata,
  output logic [XLEN-1:0]     pc_out,
  output logic [XLEN-1:0]     result_out,
  output logic                gr_we_out,
  output logic [4:0]          dest_out,
  output logic                ale_out
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = (XLEN == 64) ? 3 : 2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q, alu_q, rkd_q, result_q;
  logic            ld_q, st_q, gr_we_q, uns_q, ale_q;
  logic [4:0]      dest_q;
  logic [1:0]      size_q;

  logic            accept_d, memop_d, misalign_d;
  logic [OFFW-1:0] amask_d, off_d;
  logic [XLEN-1:0] shifted_d, lmask_d, topbit_d, load_ext_d, wdata_d;
  logic [6:0]      nbits_d;
  logic [3:0]      nbytes_d;
  logic [NB-1:0]   bmask_d;

  assign in_ready = ~rst & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept_d = in_valid & in_ready;
  assign memop_d  = res_from_mem | mem_we;

  // A double access cannot be naturally aligned on a 32-bit datapath.
  always_comb begin
    amask_d    = ~({OFFW{1'b1}} << mem_size);
    misalign_d = ((mem_size == 2'd3) && (XLEN == 32)) ||
                 ((alu_result[OFFW-1:0] & amask_d) != '0);
  end

  assign off_d = alu_q[OFFW-1:0];

  // Sign bit is located through the top bit of the width mask to avoid a
  // variable bit-select.
  always_comb begin
    shifted_d  = data_rdata >> {off_d, 3'b000};
    nbits_d    = 7'd8 << size_q;
    lmask_d    = ~({XLEN{1'b1}} << nbits_d);
    topbit_d   = lmask_d & ~(lmask_d >> 1);
    load_ext_d = shifted_d & lmask_d;
    if (!uns_q && ((shifted_d & topbit_d) != '0)) begin
      load_ext_d = load_ext_d | ~lmask_d;
    end
  end

  always_comb begin
    nbytes_d = 4'd1 << size_q;
    bmask_d  = ~({NB{1'b1}} << nbytes_d);
    case (size_q)
      2'd0:    wdata_d = {NB{rkd_q[7:0]}};
      2'd1:    wdata_d = {(NB/2){rkd_q[15:0]}};
      2'd2:    wdata_d = {(NB/4){rkd_q[31:0]}};
      default: wdata_d = rkd_q;
    endcase
  end

  assign data_req   = (state_q == S_REQ);
  assign data_wr    = st_q;
  assign data_addr  = {alu_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign data_wstrb = bmask_d << off_d;
  assign data_wdata = wdata_d;

  assign out_valid  = (state_q == S_DONE);
  assign pc_out     = pc_q;
  assign result_out = result_q;
  assign gr_we_out  = gr_we_q;
  assign dest_out   = dest_q;
  assign ale_out    = ale_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      alu_q    <= '0;
      rkd_q    <= '0;
      result_q <= '0;
      ld_q     <= 1'b0;
      st_q     <= 1'b0;
      gr_we_q  <= 1'b0;
      uns_q    <= 1'b0;
      ale_q    <= 1'b0;
      dest_q   <= '0;
      size_q   <= '0;
    end else if (accept_d) begin
      pc_q     <= pc;
      alu_q    <= alu_result;
      rkd_q    <= rkd_value;
      result_q <= alu_result;
      ld_q     <= res_from_mem;
      st_q     <= mem_we;
      gr_we_q  <= gr_we & ~(memop_d & misalign_d);
      uns_q    <= mem_unsigned;
      ale_q    <= memop_d & misalign_d;
      dest_q   <= dest;
      size_q   <= mem_size;
      state_q  <= (memop_d && !misalign_d) ? S_REQ : S_DONE;
    end else begin
      case (state_q)
        S_REQ:  if (data_addr_ok) state_q <= S_WAIT;
        S_WAIT: if (data_data_ok) begin
                  state_q <= S_DONE;
                  if (ld_q) result_q <= load_ext_d;
                end
        S_DONE: if (out_ready) state_q <= S_IDLE;
        default: ;
      endcase
    end
  end

endmodule
